sram_access_ctrl: RTL

//   Sequences and shares the 8x32 operand SRAM between three requesters: keypad entry (write),
//   ALU operand fetch (two reads, A then B) and clear-all. Sole driver of the SRAM RD/Load/Clear/

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_access_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and defaults for the operand SRAM access controller
package sram_ctrl_pkg;

    localparam int AW_DEF     = 3;
    localparam int DW_DEF     = 32;
    localparam int RD_LAT_DEF = 1;
    // Shared sweep/latency counter width; covers DEPTH-1 and RD_LAT for any sane setting.
    localparam int CW         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_A,
        ST_READ_B,
        ST_CLEAR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - arbitrates and sequences the 8x32 operand SRAM for entry, fetch and clear
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   wr_req/wr_addr/wr_data/wr_ack      keypad entry write (req held until ack pulse)
//   op_req/op_addr_a/op_addr_b         ALU operand fetch (A then B)
//   op_ack/op_a/op_b/op_err            fetch result; op_err = A or B slot never written
//   clr_req/clr_busy                   clear-all sweep (busy through the DONE cycle)
//   mem_rd/mem_load/mem_clear          SRAM control pins (registered)
//   mem_addr/mem_wdata/mem_rdata       SRAM address, dataIn, dataOut
//   valid_mask                         per-slot written-since-clear flags
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    output logic                wr_ack,
    input  logic                op_req,
    input  logic [AW-1:0]       op_addr_a,
    input  logic [AW-1:0]       op_addr_b,
    output logic                op_ack,
    output logic [DW-1:0]       op_a,
    output logic [DW-1:0]       op_b,
    output logic                op_err,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                mem_rd,
    output logic                mem_load,
    output logic                mem_clear,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic [(1<<AW)-1:0]  valid_mask
);

    localparam int DEPTH = 1 << AW;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rr_op_q, rr_op_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_load_q, mem_load_d;
    logic                mem_clear_q, mem_clear_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic                op_ack_q, op_ack_d;
    logic                op_err_q, op_err_d;
    logic                clr_busy_q, clr_busy_d;
    logic [DW-1:0]       op_a_q, op_a_d;
    logic [DW-1:0]       op_b_q, op_b_d;
    logic [DEPTH-1:0]    valid_q, valid_d;

    // Every output is a register: the next-state logic computes the pin values
    // for the state being entered, so pins change exactly at state boundaries.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_op_d     = rr_op_q;
        mem_rd_d    = 1'b1;
        mem_load_d  = 1'b0;
        mem_clear_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        op_ack_d    = 1'b0;
        op_err_d    = 1'b0;
        clr_busy_d  = 1'b0;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        valid_d     = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d     = ST_CLEAR;
                    cnt_d       = '0;
                    mem_clear_d = 1'b1;
                    mem_addr_d  = '0;
                    clr_busy_d  = 1'b1;
                end else if (wr_req && !(op_req && rr_op_q)) begin
                    state_d     = ST_WRITE;
                    mem_rd_d    = 1'b0;
                    mem_load_d  = 1'b1;
                    mem_addr_d  = wr_addr;
                    mem_wdata_d = wr_data;
                    // A fetch that lost this round gets the next one.
                    rr_op_d     = rr_op_q | op_req;
                end else if (op_req) begin
                    state_d    = ST_READ_A;
                    cnt_d      = '0;
                    mem_addr_d = op_addr_a;
                    rr_op_d    = 1'b0;
                end
            end
            ST_WRITE: begin
                valid_d[mem_addr_q] = 1'b1;
                state_d             = ST_DONE;
                wr_ack_d            = 1'b1;
            end
            ST_READ_A: begin
                if (cnt_q == CW'(RD_LAT)) begin
                    op_a_d     = mem_rdata;
                    state_d    = ST_READ_B;
                    cnt_d      = '0;
                    mem_addr_d = op_addr_b;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READ_B: begin
                if (cnt_q == CW'(RD_LAT)) begin
                    op_b_d   = mem_rdata;
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    op_ack_d = 1'b1;
                    op_err_d = ~valid_q[op_addr_a] | ~valid_q[op_addr_b];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                valid_d[cnt_q[AW-1:0]] = 1'b0;
                clr_busy_d             = 1'b1;
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mem_clear_d = 1'b1;
                    mem_addr_d  = cnt_d[AW-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rr_op_q     <= 1'b0;
            mem_rd_q    <= 1'b1;
            mem_load_q  <= 1'b0;
            mem_clear_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            op_ack_q    <= 1'b0;
            op_err_q    <= 1'b0;
            clr_busy_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_op_q     <= rr_op_d;
            mem_rd_q    <= mem_rd_d;
            mem_load_q  <= mem_load_d;
            mem_clear_q <= mem_clear_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            op_ack_q    <= op_ack_d;
            op_err_q    <= op_err_d;
            clr_busy_q  <= clr_busy_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            valid_q     <= valid_d;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign op_ack     = op_ack_q;
    assign op_err     = op_err_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign clr_busy   = clr_busy_q;
    assign mem_rd     = mem_rd_q;
    assign mem_load   = mem_load_q;
    assign mem_clear  = mem_clear_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign valid_mask = valid_q;

endmodule
